// File: rtl/ps2_key_sequencer.sv
// Host-side PS/2 key-event scheduler: round-robin arbitration of two requesters,
// Set-2 byte expansion (E0/F0 prefixes) and one-byte-in-flight pacing on byte_sent.
module ps2_key_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       ext_a,
    input  logic       brk_a,
    input  logic [7:0] code_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic       ext_b,
    input  logic       brk_b,
    input  logic [7:0] code_b,
    output logic       ack_b,
    input  logic       byte_sent,
    output logic       key_action,
    output logic [7:0] scan_code,
    output logic       busy,
    output logic       timeout_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_SENT, S_GAP} state_t;

    typedef struct packed {
        logic [1:0]      len;
        logic [2:0][7:0] bytes;
    } seq_t;

    // bytes[0] is transmitted first
    function automatic seq_t expand(input logic ext, input logic brk, input logic [7:0] code);
        seq_t s;
        s.bytes = '0;
        s.len   = 2'd1;
        case ({ext, brk})
            2'b00: begin s.bytes[0] = code;                                               s.len = 2'd1; end
            2'b01: begin s.bytes[0] = 8'hF0; s.bytes[1] = code;                           s.len = 2'd2; end
            2'b10: begin s.bytes[0] = 8'hE0; s.bytes[1] = code;                           s.len = 2'd2; end
            default: begin s.bytes[0] = 8'hE0; s.bytes[1] = 8'hF0; s.bytes[2] = code;     s.len = 2'd3; end
        endcase
        return s;
    endfunction

    state_t          state_q, state_d;
    logic            ack_a_q, ack_a_d;
    logic            ack_b_q, ack_b_d;
    logic            key_action_q, key_action_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            timeout_err_q, timeout_err_d;
    logic            last_b_q, last_b_d;
    logic [2:0][7:0] list_q, list_d;
    logic [1:0]      len_q, len_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;

    seq_t seq_a, seq_b;
    logic grant_a, grant_b;

    assign seq_a = expand(ext_a, brk_a, code_a);
    assign seq_b = expand(ext_b, brk_b, code_b);

    // A wins a tie only when B held the previous grant
    assign grant_a = req_a & (~req_b | last_b_q);
    assign grant_b = req_b & ~grant_a;

    always_comb begin
        state_d       = state_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        key_action_d  = 1'b0;
        scan_code_d   = scan_code_q;
        timeout_err_d = timeout_err_q;
        last_b_d      = last_b_q;
        list_d        = list_q;
        len_d         = len_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        gcnt_d        = gcnt_q;

        case (state_q)
            S_IDLE: begin
                if (grant_a) begin
                    ack_a_d  = 1'b1;
                    last_b_d = 1'b0;
                    list_d   = seq_a.bytes;
                    len_d    = seq_a.len;
                    idx_d    = 2'd0;
                    state_d  = S_ISSUE;
                end else if (grant_b) begin
                    ack_b_d  = 1'b1;
                    last_b_d = 1'b1;
                    list_d   = seq_b.bytes;
                    len_d    = seq_b.len;
                    idx_d    = 2'd0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                key_action_d = 1'b1;
                scan_code_d  = list_q[idx_q];
                tcnt_d       = '0;
                state_d      = S_WAIT_SENT;
            end
            S_WAIT_SENT: begin
                if (byte_sent) begin
                    idx_d   = idx_q + 2'd1;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    // abandon the rest of the sequence; GAP will then fall back to IDLE
                    timeout_err_d = 1'b1;
                    idx_d         = len_q;
                    gcnt_d        = '0;
                    state_d       = S_GAP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                if (gcnt_q == GW'(GAP_CYCLES)) begin
                    state_d = (idx_q < len_q) ? S_ISSUE : S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            key_action_q  <= 1'b0;
            scan_code_q   <= 8'h00;
            timeout_err_q <= 1'b0;
            last_b_q      <= 1'b1;
            len_q         <= 2'd0;
            idx_q         <= 2'd0;
            tcnt_q        <= '0;
            gcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            key_action_q  <= key_action_d;
            scan_code_q   <= scan_code_d;
            timeout_err_q <= timeout_err_d;
            last_b_q      <= last_b_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            tcnt_q        <= tcnt_d;
            gcnt_q        <= gcnt_d;
        end
    end

    // byte list is pure data, reloaded on every grant
    always_ff @(posedge clk) begin
        list_q <= list_d;
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign key_action  = key_action_q;
    assign scan_code   = scan_code_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: one default instance plus one with TIMEOUT=16.
module tb_ps2_key_sequencer;

    localparam int GAP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       req_a = 1'b0, ext_a = 1'b0, brk_a = 1'b0;
    logic [7:0] code_a = 8'h00;
    logic       req_b = 1'b0, ext_b = 1'b0, brk_b = 1'b0;
    logic [7:0] code_b = 8'h00;
    logic       bs = 1'b0;
    logic       ack_a, ack_b, ka, busy, terr;
    logic [7:0] sc;

    logic       t_req_a = 1'b0, t_brk_a = 1'b0;
    logic [7:0] t_code_a = 8'h00;
    logic       t_req_b = 1'b0;
    logic [7:0] t_code_b = 8'h00;
    logic       t_bs = 1'b0;
    logic       t_ack_a, t_ack_b, t_ka, t_busy, t_terr;
    logic [7:0] t_sc;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;

    ps2_key_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT(4096)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .ext_a(ext_a), .brk_a(brk_a), .code_a(code_a), .ack_a(ack_a),
        .req_b(req_b), .ext_b(ext_b), .brk_b(brk_b), .code_b(code_b), .ack_b(ack_b),
        .byte_sent(bs), .key_action(ka), .scan_code(sc), .busy(busy), .timeout_err(terr)
    );

    ps2_key_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT(16)) dut_t (
        .clk(clk), .reset(reset),
        .req_a(t_req_a), .ext_a(1'b0), .brk_a(t_brk_a), .code_a(t_code_a), .ack_a(t_ack_a),
        .req_b(t_req_b), .ext_b(1'b0), .brk_b(1'b0), .code_b(t_code_b), .ack_b(t_ack_b),
        .byte_sent(t_bs), .key_action(t_ka), .scan_code(t_sc), .busy(t_busy), .timeout_err(t_terr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_a || ack_b) ack_cnt++;
    endtask

    // clocks until key_action is seen high (bounded)
    task automatic wait_key(output int n);
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (ka) break;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_sent();
        bs = 1'b1;
        tick();
        bs = 1'b0;
    endtask

    // called right after a grant edge: single-byte sequence carrying 'code'
    task automatic do_seq(input logic [7:0] code, input string tag);
        int n;
        ack_cnt = 0;
        wait_key(n);
        check({tag, "_lat"}, n, 1);
        check({tag, "_code"}, sc, code);
        pulse_sent();
        wait_idle(n);
        check({tag, "_idle"}, n, GAP + 1);
        check({tag, "_noack"}, ack_cnt, 0);
    endtask

    initial begin
        int n;
        int strobes;
        logic exp_a;

        // reset state
        tick();
        tick();
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_ka", ka, 0);
        check("rst_sc", sc, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_terr", terr, 0);
        reset = 1'b0;
        tick();

        // make, single byte 1C
        req_a = 1'b1; ext_a = 1'b0; brk_a = 1'b0; code_a = 8'h1C;
        tick();
        check("mk_ack", ack_a, 1);
        check("mk_busy", busy, 1);
        check("mk_ka_early", ka, 0);
        req_a = 1'b0;
        tick();
        check("mk_ack_drop", ack_a, 0);
        check("mk_ka", ka, 1);
        check("mk_sc", sc, 8'h1C);
        strobes = 0;
        for (int i = 0; i < 65; i++) begin
            tick();
            if (ka) strobes++;
        end
        check("mk_nostrobe", strobes, 0);
        pulse_sent();
        wait_idle(n);
        check("mk_idle", n, GAP + 1);
        check("mk_sc_hold", sc, 8'h1C);

        // extended release on B: E0 F0 75
        req_b = 1'b1; ext_b = 1'b1; brk_b = 1'b1; code_b = 8'h75;
        tick();
        check("er_ack", ack_b, 1);
        req_b = 1'b0;
        wait_key(n);
        check("er_lat0", n, 1);
        check("er_b0", sc, 8'hE0);
        pulse_sent();  // byte_sent in the same cycle as the strobe
        wait_key(n);
        check("er_lat1", n, GAP + 2);
        check("er_b1", sc, 8'hF0);
        tick();
        tick();
        pulse_sent();
        wait_key(n);
        check("er_lat2", n, GAP + 2);
        check("er_b2", sc, 8'h75);
        pulse_sent();
        wait_idle(n);
        check("er_idle", n, GAP + 1);

        // contention after reset: A, B, A, B, A
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = 1'b1; ext_a = 1'b0; brk_a = 1'b0; code_a = 8'h11;
        req_b = 1'b1; ext_b = 1'b0; brk_b = 1'b0; code_b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            exp_a = (i % 2 == 0);
            tick();
            check($sformatf("rr%0d_ack_a", i), ack_a, exp_a);
            check($sformatf("rr%0d_ack_b", i), ack_b, !exp_a);
            if (i == 4) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            do_seq(exp_a ? 8'h11 : 8'h22, $sformatf("rr%0d", i));
        end

        // second byte withheld until byte_sent
        req_a = 1'b1; ext_a = 1'b0; brk_a = 1'b1; code_a = 8'h12;
        tick();
        check("hd_ack", ack_a, 1);
        req_a = 1'b0;
        wait_key(n);
        check("hd_b0", sc, 8'hF0);
        strobes = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ka) strobes++;
        end
        check("hd_nostrobe", strobes, 0);
        check("hd_busy", busy, 1);
        pulse_sent();
        wait_key(n);
        check("hd_lat", n, GAP + 2);
        check("hd_b1", sc, 8'h12);
        pulse_sent();
        wait_idle(n);
        check("hd_idle", n, GAP + 1);

        // timeout on the TIMEOUT=16 instance: {F0, 2A}, byte_sent never given
        t_req_a = 1'b1; t_brk_a = 1'b1; t_code_a = 8'h2A;
        tick();
        check("to_ack", t_ack_a, 1);
        t_req_a = 1'b0;
        tick();
        check("to_ka", t_ka, 1);
        check("to_b0", t_sc, 8'hF0);
        strobes = 0;
        n = 0;
        while (!t_terr && n < 100) begin
            tick();
            n++;
            if (t_ka) strobes++;
        end
        check("to_delay", n, 16);
        n = 0;
        while (t_busy && n < 100) begin
            tick();
            n++;
            if (t_ka) strobes++;
        end
        check("to_idle", n, GAP + 1);
        check("to_nostrobe", strobes, 0);
        check("to_sc_hold", t_sc, 8'hF0);
        t_req_b = 1'b1; t_code_b = 8'h33;
        tick();
        check("to_next_ack", t_ack_b, 1);
        t_req_b = 1'b0;
        tick();
        check("to_next_ka", t_ka, 1);
        check("to_next_sc", t_sc, 8'h33);
        t_bs = 1'b1;
        tick();
        t_bs = 1'b0;
        check("to_sticky", t_terr, 1);
        for (int i = 0; i < GAP + 1; i++) tick();
        check("to_next_idle", t_busy, 0);

        // reset while waiting on the E0 byte
        req_a = 1'b1; ext_a = 1'b1; brk_a = 1'b0; code_a = 8'h70;
        tick();
        req_a = 1'b0;
        wait_key(n);
        check("mr_b0", sc, 8'hE0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_ack_a", ack_a, 0);
        check("mr_ka", ka, 0);
        check("mr_sc", sc, 8'h00);
        check("mr_busy", busy, 0);
        check("mr_terr", terr, 0);
        check("mr_t_terr", t_terr, 0);
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            bs = (i == 10);
            tick();
            if (ka) strobes++;
        end
        bs = 1'b0;
        check("mr_nostrobe", strobes, 0);
        check("mr_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
